// File: rtl/psram_qpi_responder.sv
// ============================================================================
// Module  : psram_qpi_responder
// Brief   : Device end of a quad-SPI PSRAM bus. Decodes the SPI QPI-enable
//           command and QPI write/read bursts into a local byte array.
//           Define PSRAM_PAGE_WRAP_EN to keep bursts inside a 1024-byte page.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psram_qpi_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       i_clkRAM,
  input  logic       reset,
  input  logic       i_psram_cs,
  inout  wire        io_psram_data0,
  inout  wire        io_psram_data1,
  inout  wire        io_psram_data2,
  inout  wire        io_psram_data3,
  output logic       o_qpiMode,
  output logic [7:0] o_cmd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WAIT   = 3'd3,
    S_WRDATA = 3'd4,
    S_RDDATA = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  localparam int unsigned          DEPTH        = 2 ** ADDR_BITS;
  localparam logic [7:0]           CMD_QPI_EN   = 8'h35;
  localparam logic [7:0]           CMD_QPI_EXIT = 8'hF5;
  localparam logic [7:0]           CMD_WRITE    = 8'h38;
  localparam logic [7:0]           CMD_READ     = 8'hEB;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE     = ADDR_BITS'(1);
`ifdef PSRAM_PAGE_WRAP_EN
  localparam logic [ADDR_BITS-1:0] INC_MASK = (ADDR_BITS > 10) ? ADDR_BITS'(1023) : '1;
`else
  localparam logic [ADDR_BITS-1:0] INC_MASK = '1;
`endif

  logic [7:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic                   qpi_q, qpi_d;
  logic                   pend_set_q, pend_set_d;
  logic                   pend_clr_q, pend_clr_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [6:0]             cmd_sh_q, cmd_sh_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   half_q, half_d;
  logic [3:0]             wr_hi_q, wr_hi_d;
  logic [3:0]             dout_q, dout_d;
  logic                   oe_q, oe_d;

  logic [3:0]             nib;
  logic [7:0]             cmd_byte;
  logic [ADDR_BITS-1:0]   addr_inc;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [7:0]             rd_byte;
  logic                   mem_we;
  logic                   drive_en;

  assign nib      = {io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};
  assign cmd_byte = qpi_q ? {cmd_sh_q[3:0], nib} : {cmd_sh_q, io_psram_data0};
  // Bits outside INC_MASK hold, so page wrap and linear wrap share one path.
  assign addr_inc = (addr_q & ~INC_MASK) | ((addr_q + ADDR_ONE) & INC_MASK);
  assign rd_addr  = (state_q == S_RDDATA && half_q) ? addr_inc : addr_q;
  assign rd_byte  = mem[rd_addr];

  always_comb begin
    state_d    = state_q;
    qpi_d      = qpi_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    cmd_d      = cmd_q;
    cmd_sh_d   = cmd_sh_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    half_d     = half_q;
    wr_hi_d    = wr_hi_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    mem_we     = 1'b0;
    if (i_psram_cs) begin
      state_d    = S_IDLE;
      cnt_d      = 8'd0;
      half_d     = 1'b0;
      oe_d       = 1'b0;
      pend_set_d = 1'b0;
      pend_clr_d = 1'b0;
      if (pend_set_q)      qpi_d = 1'b1;
      else if (pend_clr_q) qpi_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_CMD: begin
          cmd_sh_d = cmd_byte[6:0];
          cnt_d    = cnt_q + 8'd1;
          state_d  = S_CMD;
          if ((qpi_q && cnt_q == 8'd1) || (!qpi_q && cnt_q == 8'd7)) begin
            cmd_d   = cmd_byte;
            cnt_d   = 8'd0;
            state_d = S_IGNORE;
            if (!qpi_q && cmd_byte == CMD_QPI_EN)        pend_set_d = 1'b1;
            else if (qpi_q && cmd_byte == CMD_QPI_EXIT)  pend_clr_d = 1'b1;
            else if (qpi_q && (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ))
              state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          addr_d = {addr_q[ADDR_BITS-5:0], nib};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d   = 8'd0;
            half_d  = 1'b0;
            state_d = (cmd_q == CMD_WRITE) ? S_WRDATA : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
            cnt_d   = 8'd0;
            dout_d  = rd_byte[7:4];
            oe_d    = 1'b1;
            half_d  = 1'b0;
            state_d = S_RDDATA;
          end
        end
        S_RDDATA: begin
          if (!half_q) begin
            dout_d = rd_byte[3:0];
            half_d = 1'b1;
          end else begin
            addr_d = addr_inc;
            dout_d = rd_byte[7:4];
            half_d = 1'b0;
          end
        end
        S_WRDATA: begin
          if (!half_q) begin
            wr_hi_d = nib;
            half_d  = 1'b1;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_inc;
            half_d = 1'b0;
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      qpi_q      <= 1'b0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      cmd_q      <= 8'h00;
      cmd_sh_q   <= 7'h00;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      half_q     <= 1'b0;
      wr_hi_q    <= 4'h0;
      dout_q     <= 4'h0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      qpi_q      <= qpi_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      cmd_q      <= cmd_d;
      cmd_sh_q   <= cmd_sh_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      half_q     <= half_d;
      wr_hi_q    <= wr_hi_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
    end
  end

  // Array has no reset so its contents survive a controller reset.
  always_ff @(posedge i_clkRAM) begin
    if (mem_we) mem[addr_q] <= {wr_hi_q, nib};
  end

  assign drive_en       = oe_q & qpi_q & ~i_psram_cs;
  assign io_psram_data0 = drive_en ? dout_q[0] : 1'bz;
  assign io_psram_data1 = drive_en ? dout_q[1] : 1'bz;
  assign io_psram_data2 = drive_en ? dout_q[2] : 1'bz;
  assign io_psram_data3 = drive_en ? dout_q[3] : 1'bz;

  assign o_qpiMode = qpi_q;
  assign o_cmd     = cmd_q;

endmodule

`default_nettype wire
